layer_gate_accum: RTL and testbench

LAYER_GATE_ACCUM -- requirements
Module: layer_gate_accum

---
 rtl/layer_gate_accum.sv | 117 +++++++++++
 tb/tb_layer_gate_accum.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_gate_accum.sv
// layer_gate_accum
//   Sums the three evaluation points of ngates per-gate compute units into a
//   three-element field accumulator, one gate per cycle, modulo F_Q.
//   A round starts on a rising edge of en while idle. It then waits for every
//   gate to report ready and accumulates gates 0..ngates-1 in turn.
//
// Ports
//   clk          single clock, all state on its rising edge
//   rstb         synchronous active-low reset
//   en           start request (rising-edge detected, ignored while busy)
//   gate_ready   per-gate ready; only looked at on start and in WAIT
//   gate_in      element 3*g+k = gate g evaluated at point k (k = 0..2)
//   ready        idle and sum_out valid (drops combinationally on start)
//   ready_pulse  one-cycle pulse on the rising edge of ready
//   sum_out      element k = sum over gates of gate_in[3*g+k], mod F_Q

`ifndef F_NBITS
`define F_NBITS 8
`endif
`ifndef F_Q
`define F_Q 251
`endif

module layer_gate_accum #(
   parameter int ngates = 8,
   parameter int ngbits = (ngates > 1) ? $clog2(ngates) : 1
) (
   input  logic                clk,
   input  logic                rstb,
   input  logic                en,
   input  logic [ngates-1:0]   gate_ready,
   input  logic [`F_NBITS-1:0] gate_in [3*ngates-1:0],
   output logic                ready,
   output logic                ready_pulse,
   output logic [`F_NBITS-1:0] sum_out [2:0]
);

   localparam int         W = `F_NBITS;
   localparam logic [W:0] Q = (W+1)'(`F_Q);

   typedef enum logic [1:0] {IDLE, WAIT, ACC} state_t;

   state_t            state_q, state_d;
   logic [ngbits-1:0] cnt_q, cnt_d;
   logic [W-1:0]      sum_q [2:0];
   logic [W-1:0]      sum_d [2:0];
   logic [W-1:0]      acc_sum [2:0];
   logic              en_dly_q, en_dly_d;
   logic              ready_dly_q, ready_dly_d;
   logic              start;

   // Operands are canonical (< F_Q), so one conditional subtract suffices;
   // the extra carry bit keeps a+b from wrapping before the compare.
   function automatic logic [W-1:0] modadd(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= Q) s = s - Q;
      return s[W-1:0];
   endfunction

   // Three evaluation points accumulate in parallel from the current gate.
   for (genvar k = 0; k < 3; k++) begin : g_pt
      assign acc_sum[k] = modadd(sum_q[k], gate_in[3*int'(cnt_q) + k]);
   end

   assign start       = en & ~en_dly_q & (state_q == IDLE);
   assign ready       = (state_q == IDLE) & ~start;
   assign ready_pulse = ready & ~ready_dly_q;
   assign sum_out     = sum_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      sum_d       = sum_q;
      en_dly_d    = en;
      ready_dly_d = ready;
      case (state_q)
         IDLE: begin
            if (start) begin
               sum_d   = '{default: '0};
               cnt_d   = '0;
               state_d = (&gate_ready) ? ACC : WAIT;
            end
         end
         WAIT: begin
            if (&gate_ready) state_d = ACC;
         end
         ACC: begin
            sum_d = acc_sum;
            // The counter parks on the last gate rather than wrapping; the
            // next start clears it.
            if (cnt_q == ngbits'(ngates - 1)) state_d = IDLE;
            else                              cnt_d   = cnt_q + ngbits'(1);
         end
         default: state_d = IDLE;
      endcase
   end

   // en_dly/ready_dly reset high so a level held across reset is not seen as
   // an edge, and no ready_pulse fires on the first idle cycle.
   always_ff @(posedge clk) begin
      if (!rstb) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         sum_q       <= '{default: '0};
         en_dly_q    <= 1'b1;
         ready_dly_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sum_q       <= sum_d;
         en_dly_q    <= en_dly_d;
         ready_dly_q <= ready_dly_d;
      end
   end

endmodule

// File: tb/tb_layer_gate_accum.sv
// Directed + randomized bench for layer_gate_accum. Main instance uses
// ngates=4; two small instances (ngates=2, ngates=1) cover the narrow cases.

`ifndef F_NBITS
`define F_NBITS 8
`endif
`ifndef F_Q
`define F_Q 251
`endif

module tb_layer_gate_accum;
   localparam int W = `F_NBITS;
   localparam int Q = `F_Q;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rstb;
   // ngates = 4
   logic         en4;
   logic [3:0]   gr4;
   logic [W-1:0] gin4 [11:0];
   logic         rdy4, rp4;
   logic [W-1:0] sum4 [2:0];
   // ngates = 2 and ngates = 1, shared start
   logic         ens;
   logic [1:0]   gr2;
   logic [0:0]   gr1;
   logic [W-1:0] gin2 [5:0];
   logic [W-1:0] gin1 [2:0];
   logic         rdy2, rp2, rdy1, rp1;
   logic [W-1:0] sum2 [2:0];
   logic [W-1:0] sum1 [2:0];

   int checks = 0;
   int errors = 0;

   layer_gate_accum #(.ngates(4)) dut4 (
      .clk(clk), .rstb(rstb), .en(en4), .gate_ready(gr4), .gate_in(gin4),
      .ready(rdy4), .ready_pulse(rp4), .sum_out(sum4));

   layer_gate_accum #(.ngates(2)) dut2 (
      .clk(clk), .rstb(rstb), .en(ens), .gate_ready(gr2), .gate_in(gin2),
      .ready(rdy2), .ready_pulse(rp2), .sum_out(sum2));

   layer_gate_accum #(.ngates(1)) dut1 (
      .clk(clk), .rstb(rstb), .en(ens), .gate_ready(gr1), .gate_in(gin1),
      .ready(rdy1), .ready_pulse(rp1), .sum_out(sum1));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: plain integer sum of the point-k column, reduced mod Q.
   function automatic int ref4(input int k);
      int s = 0;
      for (int g = 0; g < 4; g++) s += int'(gin4[3*g+k]);
      return s % Q;
   endfunction

   function automatic int ref2(input int k);
      int s = 0;
      for (int g = 0; g < 2; g++) s += int'(gin2[3*g+k]);
      return s % Q;
   endfunction

   task automatic rand_gin4();
      for (int i = 0; i < 12; i++) gin4[i] = W'($urandom_range(0, Q-1));
   endtask

   task automatic check_sums4(input string tag);
      for (int k = 0; k < 3; k++) check($sformatf("%s_sum%0d", tag, k), sum4[k], ref4(k));
   endtask

   // One round on dut4. waits = cycles bit 3 of gate_ready stays low after
   // start; poke = extra en edge two cycles into ACC. Returns in the ready
   // cycle (no trailing tick) so a caller can start back-to-back.
   task automatic run4(input int waits, input bit poke, input string tag);
      int cyc;
      int pulses;
      gr4 = (waits > 0) ? 4'b0111 : 4'b1111;
      en4 = 1'b1;
      #1;
      check({tag, "_start_ready_low"}, rdy4, 0);
      tick();
      en4 = 1'b0;
      pulses = 0;
      for (cyc = 1; cyc < 40; cyc++) begin
         if (cyc == waits) gr4 = 4'b1111;
         else if (cyc > waits) gr4 = 4'($urandom);   // must be ignored in ACC
         if (poke) en4 = (cyc == waits + 2);
         #1;
         if (rdy4) break;
         if (rp4) pulses++;
         tick();
      end
      check({tag, "_latency"}, cyc, waits + 5);
      check({tag, "_busy_pulse"}, pulses, 0);
      check({tag, "_pulse"}, rp4, 1);
      check_sums4(tag);
   endtask

   // One shared start on dut2/dut1; dut1 must finish a cycle before dut2.
   task automatic run_small(input int v, input bit rnd, input string tag);
      int t1, t2;
      int exp1 [3];
      for (int i = 0; i < 6; i++) gin2[i] = rnd ? W'($urandom_range(0, Q-1)) : W'(v);
      for (int i = 0; i < 3; i++) begin
         gin1[i] = W'($urandom_range(0, Q-1));
         exp1[i] = int'(gin1[i]);
      end
      ens = 1'b1;
      #1;
      check({tag, "_start2"}, rdy2, 0);
      tick();
      ens = 1'b0;
      t1 = 0;
      t2 = 0;
      for (int c = 1; c <= 10; c++) begin
         if (rdy1 && t1 == 0) t1 = c;
         if (rdy2 && t2 == 0) t2 = c;
         if (t2 != 0) break;
         tick();
      end
      check({tag, "_lat1"}, t1, 2);
      check({tag, "_lat2"}, t2, 3);
      check({tag, "_pulse2"}, rp2, 1);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("%s_s2_%0d", tag, k), sum2[k], ref2(k));
         check($sformatf("%s_s1_%0d", tag, k), sum1[k], exp1[k]);
      end
      tick();
   endtask

   initial begin
      int pulses;
      rstb = 1'b0;
      en4  = 1'b1;          // held high across reset: must not start
      ens  = 1'b0;
      gr4  = 4'b1111;
      gr2  = 2'b11;
      gr1  = 1'b1;
      for (int i = 0; i < 12; i++) gin4[i] = '0;
      for (int i = 0; i < 6; i++) gin2[i] = '0;
      for (int i = 0; i < 3; i++) gin1[i] = '0;
      tick();
      tick();
      check("rst_ready", rdy4, 1);
      check("rst_pulse", rp4, 0);
      for (int k = 0; k < 3; k++) check($sformatf("rst_sum%0d", k), sum4[k], 0);

      rstb = 1'b1;
      pulses = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (!rdy4) pulses++;
      end
      check("held_en_no_start", pulses, 0);
      check("held_en_pulse", rp4, 0);
      en4 = 1'b0;
      tick();

      // Known pattern gin[3g+k] = g+k.
      for (int g = 0; g < 4; g++)
         for (int k = 0; k < 3; k++) gin4[3*g+k] = W'(g + k);
      run4(0, 1'b0, "basic");
      check("basic_c0", sum4[0], 6);
      check("basic_c1", sum4[1], 10);
      check("basic_c2", sum4[2], 14);
      tick();
      check("basic_pulse_once", rp4, 0);
      check("basic_hold_ready", rdy4, 1);
      check_sums4("basic_hold");

      rand_gin4();
      run4(3, 1'b0, "wait3");
      tick();

      rand_gin4();
      run4(0, 1'b1, "poke");
      tick();

      // en held high for 10 cycles: exactly one round.
      rand_gin4();
      gr4 = 4'b1111;
      en4 = 1'b1;
      pulses = 0;
      for (int i = 0; i < 16; i++) begin
         if (i == 10) en4 = 1'b0;
         #1;
         if (rp4) pulses++;
         tick();
      end
      check("hold_one_round", pulses, 1);
      check_sums4("hold");

      // Back-to-back rounds with new data on the ready cycle.
      rand_gin4();
      run4(0, 1'b0, "b2b_a");
      rand_gin4();
      run4(0, 1'b0, "b2b_b");
      tick();

      for (int r = 0; r < 6; r++) begin
         rand_gin4();
         run4(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $sformatf("rnd%0d", r));
         tick();
      end

      // Reset mid-ACC aborts the round.
      for (int i = 0; i < 12; i++) gin4[i] = W'($urandom_range(1, Q-1));
      gr4 = 4'b1111;
      en4 = 1'b1;
      tick();
      en4 = 1'b0;
      tick();
      rstb = 1'b0;
      tick();
      check("abort_ready", rdy4, 1);
      check("abort_pulse", rp4, 0);
      for (int k = 0; k < 3; k++) check($sformatf("abort_sum%0d", k), sum4[k], 0);
      rstb = 1'b1;
      tick();
      for (int g = 0; g < 4; g++)
         for (int k = 0; k < 3; k++) gin4[3*g+k] = W'(g + k);
      run4(0, 1'b0, "post_rst");
      check("post_rst_c2", sum4[2], 14);
      tick();

      run_small(Q - 1, 1'b0, "max");
      run_small(1, 1'b0, "ones");
      run_small(0, 1'b1, "rsmall");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
